// File: rtl/bcd_seq_checker_if.sv
// Sample/control and status bundle between a BCD decade-counter checker and its driver.
// Widths of the two counters follow the checker's ERR_W / WRAP_W parameters.
interface bcd_seq_checker_if #(
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
);
    logic              sample_en;
    logic [3:0]        q;
    logic              r0;
    logic              r9;
    logic              clr;
    logic [3:0]        exp_q;
    logic              locked;
    logic              err;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_cnt;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output sample_en, q, r0, r9, clr,
        input  exp_q, locked, err, err_sticky, err_cnt, wrap, wrap_cnt
    );

    modport slave (
        input  sample_en, q, r0, r9, clr,
        output exp_q, locked, err, err_sticky, err_cnt, wrap, wrap_cnt
    );
endinterface

// File: rtl/bcd_seq_checker.sv
// Tracks a 7490-style BCD decade counter sample by sample, flags illegal or
// out-of-sequence values and counts errors and natural 9->0 wraps.
module bcd_seq_checker #(
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_seq_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t            state_q, state_d;
    logic [3:0]        exp_q_q, exp_q_d;
    logic              last_forced_q, last_forced_d;
    logic              err_d, wrap_d;
    logic              err_q, wrap_q, sticky_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [WRAP_W-1:0] wrap_cnt_q;

    logic       forced;
    logic [3:0] forced_val;
    logic       legal;
    logic [3:0] q_next;
    logic       accept;
    logic [3:0] ref_val;

    // r9 dominates r0 when both controls were applied.
    assign forced     = bus.r9 | bus.r0;
    assign forced_val = bus.r9 ? 4'd9 : 4'd0;
    assign legal      = (bus.q <= 4'd9);
    assign q_next     = (bus.q == 4'd9) ? 4'd0 : bus.q + 4'd1;
    assign accept     = forced ? (bus.q == forced_val) : legal;
    assign ref_val    = forced ? forced_val : exp_q_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        exp_q_d       = exp_q_q;
        last_forced_d = last_forced_q;
        err_d         = 1'b0;
        wrap_d        = 1'b0;
        if (bus.sample_en) begin
            case (state_q)
                LOCKED: begin
                    if (bus.q == ref_val) begin
                        exp_q_d       = q_next;
                        last_forced_d = forced;
                        // A 0 following a forced 9 is not a natural decade wrap.
                        wrap_d        = !forced && !last_forced_q &&
                                        (exp_q_q == 4'd0) && (bus.q == 4'd0);
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESYNC;
                        exp_q_d = legal ? q_next : 4'd0;
                    end
                end
                IDLE, RESYNC: begin
                    if (accept) begin
                        state_d       = LOCKED;
                        exp_q_d       = q_next;
                        last_forced_d = forced;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            exp_q_q       <= 4'd0;
            last_forced_q <= 1'b0;
            err_q         <= 1'b0;
            wrap_q        <= 1'b0;
            sticky_q      <= 1'b0;
            err_cnt_q     <= '0;
            wrap_cnt_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q       <= state_d;
            exp_q_q       <= exp_q_d;
            last_forced_q <= last_forced_d;
            err_q         <= err_d;
            wrap_q        <= wrap_d;
            if (bus.clr) begin
                sticky_q   <= err_d;
                err_cnt_q  <= err_d ? ERR_W'(1) : '0;
                wrap_cnt_q <= wrap_d ? WRAP_W'(1) : '0;
            end else begin
                sticky_q <= sticky_q | err_d;
                if (err_d && (err_cnt_q != ERR_MAX))
                    err_cnt_q <= err_cnt_q + ERR_W'(1);
                if (wrap_d)
                    wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
            end
        end
    end

    assign bus.exp_q      = exp_q_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.wrap       = wrap_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
endmodule
